operand_fetch: RTL and testbench

//  Read side of the 16-entry register file. Accepts operand-read requests (two 4-bit register

---
 rtl/reg_pkg.sv | 30 +++
 rtl/operand_slot.sv | 45 ++++
 rtl/operand_fetch.sv | 140 ++++++++++++++
 tb/tb_operand_fetch.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared constants and types for the register-file read path.
// Holds the occupancy encoding and the write-snoop bypass helper.
package reg_pkg;

  localparam int N      = 16;
  localparam int NREG   = 16;
  localparam int REG_AW = 4;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_FULL  = OCC_FULL
  } occ_t;

  // A register-file write landing on this edge overrides the older value.
  function automatic logic [N-1:0] bypass(
    input logic              w,
    input logic [REG_AW-1:0] select_register,
    input logic [N-1:0]      s,
    input logic [REG_AW-1:0] code,
    input logic [N-1:0]      cur
  );
    return (w && (select_register == code)) ? s : cur;
  endfunction

endpackage

// File: rtl/operand_slot.sv
// One operand buffer entry: register codes, operand values and a valid flag.
// Loads apply the write snoop to the incoming data; held entries keep snooping.
module operand_slot
  import reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drop,
  input  logic [REG_AW-1:0] load_ra,
  input  logic [REG_AW-1:0] load_rb,
  input  logic [N-1:0]      load_a,
  input  logic [N-1:0]      load_b,
  input  logic              w,
  input  logic [REG_AW-1:0] select_register,
  input  logic [N-1:0]      s,
  output logic              valid,
  output logic [REG_AW-1:0] ra,
  output logic [REG_AW-1:0] rb,
  output logic [N-1:0]      a,
  output logic [N-1:0]      b
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      ra    <= '0;
      rb    <= '0;
      a     <= '0;
      b     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ra    <= load_ra;
      rb    <= load_rb;
      a     <= bypass(w, select_register, s, load_ra, load_a);
      b     <= bypass(w, select_register, s, load_rb, load_b);
    end else if (drop) begin
      valid <= 1'b0;
    end else if (valid) begin
      a <= bypass(w, select_register, s, ra, a);
      b <= bypass(w, select_register, s, rb, b);
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Register-file read front end: two-entry FIFO of operand pairs with
// write snooping so every delivered operand reflects the latest write.
module operand_fetch
  import reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NREG*N-1:0] regs_flat,
  input  logic              w,
  input  logic [REG_AW-1:0] select_register,
  input  logic [N-1:0]      s,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [N-1:0]      op_a,
  output logic [N-1:0]      op_b,
  output logic [REG_AW-1:0] op_ra,
  output logic [REG_AW-1:0] op_rb
);

  occ_t state_reg;

  logic [N-1:0] regs [NREG];

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_unpack
      assign regs[gi] = regs_flat[gi*N +: N];
    end
  endgenerate

  logic accept, deliver;
  logic head_load, head_drop, head_from_tail;
  logic tail_load, tail_drop;

  logic              head_valid, tail_valid;
  logic [REG_AW-1:0] tail_ra, tail_rb;
  logic [N-1:0]      tail_a, tail_b;

  logic [REG_AW-1:0] head_in_ra, head_in_rb;
  logic [N-1:0]      head_in_a, head_in_b;
  logic              unused_valid;

  assign req_ready = rst & (state_reg != ST_FULL);
  assign op_valid  = (state_reg != ST_EMPTY);
  assign accept    = req_valid & req_ready;
  assign deliver   = op_valid & op_ready;

  // Slot valid flags mirror the occupancy state; kept for slot self-containment.
  assign unused_valid = head_valid ^ tail_valid;

  always_comb begin
    head_load      = 1'b0;
    head_drop      = 1'b0;
    head_from_tail = 1'b0;
    tail_load      = 1'b0;
    tail_drop      = 1'b0;
    case (state_reg)
      ST_EMPTY: head_load = accept;
      ST_ONE: begin
        if (accept) begin
          if (deliver) head_load = 1'b1;
          else         tail_load = 1'b1;
        end else if (deliver) begin
          head_drop = 1'b1;
        end
      end
      ST_FULL: begin
        if (deliver) begin
          head_load      = 1'b1;
          head_from_tail = 1'b1;
          tail_drop      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign head_in_ra = head_from_tail ? tail_ra : ra;
  assign head_in_rb = head_from_tail ? tail_rb : rb;
  assign head_in_a  = head_from_tail ? tail_a  : regs[ra];
  assign head_in_b  = head_from_tail ? tail_b  : regs[rb];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: if (accept) state_reg <= ST_ONE;
        ST_ONE: begin
          if (accept && !deliver)      state_reg <= ST_FULL;
          else if (deliver && !accept) state_reg <= ST_EMPTY;
        end
        ST_FULL:  if (deliver) state_reg <= ST_ONE;
        default:  state_reg <= ST_EMPTY;
      endcase
    end
  end

  operand_slot u_head (
    .clk             (clk),
    .rst             (rst),
    .load            (head_load),
    .drop            (head_drop),
    .load_ra         (head_in_ra),
    .load_rb         (head_in_rb),
    .load_a          (head_in_a),
    .load_b          (head_in_b),
    .w               (w),
    .select_register (select_register),
    .s               (s),
    .valid           (head_valid),
    .ra              (op_ra),
    .rb              (op_rb),
    .a               (op_a),
    .b               (op_b)
  );

  operand_slot u_tail (
    .clk             (clk),
    .rst             (rst),
    .load            (tail_load),
    .drop            (tail_drop),
    .load_ra         (ra),
    .load_rb         (rb),
    .load_a          (regs[ra]),
    .load_b          (regs[rb]),
    .w               (w),
    .select_register (select_register),
    .s               (s),
    .valid           (tail_valid),
    .ra              (tail_ra),
    .rb              (tail_rb),
    .a               (tail_a),
    .b               (tail_b)
  );

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus a randomized
// run against a queue-based model of the buffer and a behavioural register file.
module tb_operand_fetch;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] regs_flat;
  logic         w;
  logic [3:0]   select_register;
  logic [15:0]  s;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   ra, rb;
  logic         op_valid;
  logic         op_ready;
  logic [15:0]  op_a, op_b;
  logic [3:0]   op_ra, op_rb;

  logic [15:0] regs [16];

  typedef struct {
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] a;
    logic [15:0] b;
  } ent_t;

  ent_t q[$];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < 16; i++) regs_flat[i*16 +: 16] = regs[i];
  end

  operand_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .regs_flat       (regs_flat),
    .w               (w),
    .select_register (select_register),
    .s               (s),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .ra              (ra),
    .rb              (rb),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .op_a            (op_a),
    .op_b            (op_b),
    .op_ra           (op_ra),
    .op_rb           (op_rb)
  );

  // Advance one clock; update the FIFO model and the register file behind it.
  task automatic cycle();
    bit   acc, del;
    ent_t e;
    acc = rst && req_valid && (q.size() < 2);
    del = rst && (q.size() > 0) && op_ready;
    @(posedge clk);
    #1;
    if (!rst) begin
      q.delete();
    end else begin
      if (del) void'(q.pop_front());
      if (w) begin
        foreach (q[i]) begin
          if (q[i].ra == select_register) q[i].a = s;
          if (q[i].rb == select_register) q[i].b = s;
        end
      end
      if (acc) begin
        e.ra = ra;
        e.rb = rb;
        e.a  = (w && select_register == ra) ? s : regs[ra];
        e.b  = (w && select_register == rb) ? s : regs[rb];
        q.push_back(e);
      end
    end
    if (w) regs[select_register] = s;
  endtask

  task automatic idle_inputs();
    w = 1'b0; select_register = '0; s = '0;
    req_valid = 1'b0; ra = '0; rb = '0; op_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    cycle();
    cycle();
    compared++;
    if (op_valid !== 1'b0) begin mismatched++; $display("FAIL reset_op_valid: got %b want 0", op_valid); end
    compared++;
    if (req_ready !== 1'b0) begin mismatched++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    compared++;
    if (op_a !== 16'h0 || op_b !== 16'h0) begin
      mismatched++; $display("FAIL reset_operands: got a=%h b=%h want 0/0", op_a, op_b);
    end
    rst = 1'b1;
    cycle();
    compared++;
    if (req_ready !== 1'b1) begin mismatched++; $display("FAIL release_req_ready: got %b want 1", req_ready); end
    $display("test_reset done");
  endtask

  task automatic test_basic_read();
    regs[3] = 16'h1234;
    regs[7] = 16'hBEEF;
    req_valid = 1'b1; ra = 4'd3; rb = 4'd7; op_ready = 1'b1;
    cycle();
    req_valid = 1'b0;
    compared++;
    if (op_valid !== 1'b1 || op_a !== 16'h1234 || op_b !== 16'hBEEF || op_ra !== 4'd3 || op_rb !== 4'd7) begin
      mismatched++;
      $display("FAIL basic_read: got v=%b a=%h b=%h ra=%0d rb=%0d want v=1 a=1234 b=beef ra=3 rb=7",
               op_valid, op_a, op_b, op_ra, op_rb);
    end
    cycle();
    compared++;
    if (op_valid !== 1'b0) begin mismatched++; $display("FAIL basic_drain: got op_valid=%b want 0", op_valid); end
    $display("test_basic_read done");
  endtask

  task automatic test_bypass();
    regs[5] = 16'h0011;
    req_valid = 1'b1; ra = 4'd5; rb = 4'd5; op_ready = 1'b0;
    w = 1'b1; select_register = 4'd5; s = 16'h00AA;
    cycle();
    req_valid = 1'b0; w = 1'b0;
    compared++;
    if (op_a !== 16'h00AA || op_b !== 16'h00AA) begin
      mismatched++; $display("FAIL same_cycle_bypass: got a=%h b=%h want 00aa/00aa", op_a, op_b);
    end
    op_ready = 1'b1;
    cycle();
    op_ready = 1'b0;
    $display("test_bypass done");
  endtask

  task automatic test_back_pressure();
    regs[2] = 16'h2222; regs[0] = 16'h0F0F; regs[9] = 16'h9999;
    op_ready = 1'b0;
    req_valid = 1'b1; ra = 4'd2; rb = 4'd0;
    cycle();
    ra = 4'd2; rb = 4'd9;
    cycle();
    req_valid = 1'b0;
    compared++;
    if (req_ready !== 1'b0 || op_valid !== 1'b1) begin
      mismatched++; $display("FAIL full_flags: got req_ready=%b op_valid=%b want 0/1", req_ready, op_valid);
    end
    w = 1'b1; select_register = 4'd2; s = 16'h7777;
    cycle();
    w = 1'b0;
    compared++;
    if (op_a !== 16'h7777 || op_rb !== 4'd0) begin
      mismatched++; $display("FAIL snoop_head: got a=%h rb=%0d want 7777/0", op_a, op_rb);
    end
    op_ready = 1'b1;
    cycle();
    compared++;
    if (op_a !== 16'h7777 || op_b !== 16'h9999 || op_rb !== 4'd9 || req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL snoop_tail: got a=%h b=%h rb=%0d req_ready=%b want 7777/9999/9/1",
               op_a, op_b, op_rb, req_ready);
    end
    cycle();
    compared++;
    if (op_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drain: got op_valid=%b want 0", op_valid); end
    op_ready = 1'b0;
    $display("test_back_pressure done");
  endtask

  task automatic test_streaming();
    logic [3:0] xa, xb;
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    req_valid = 1'b1; op_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      xa = 4'(i);
      xb = 4'(15 - i);
      ra = xa; rb = xb;
      cycle();
      compared++;
      if (op_valid !== 1'b1 || req_ready !== 1'b1 || op_ra !== xa || op_rb !== xb ||
          op_a !== regs[xa] || op_b !== regs[xb]) begin
        mismatched++;
        $display("FAIL stream_%0d: got v=%b rdy=%b ra=%0d rb=%0d a=%h b=%h want 1/1/%0d/%0d/%h/%h",
                 i, op_valid, req_ready, op_ra, op_rb, op_a, op_b, xa, xb, regs[xa], regs[xb]);
      end
    end
    req_valid = 1'b0;
    cycle();
    op_ready = 1'b0;
    $display("test_streaming done");
  endtask

  task automatic test_reset_mid();
    op_ready = 1'b0;
    req_valid = 1'b1; ra = 4'd1; rb = 4'd2;
    cycle();
    ra = 4'd4; rb = 4'd6;
    cycle();
    req_valid = 1'b0;
    compared++;
    if (req_ready !== 1'b0) begin mismatched++; $display("FAIL mid_full: got req_ready=%b want 0", req_ready); end
    rst = 1'b0;
    cycle();
    compared++;
    if (op_valid !== 1'b0 || req_ready !== 1'b0 || op_a !== 16'h0 || op_ra !== 4'd0) begin
      mismatched++;
      $display("FAIL mid_reset: got v=%b rdy=%b a=%h ra=%0d want 0/0/0000/0", op_valid, req_ready, op_a, op_ra);
    end
    rst = 1'b1;
    op_ready = 1'b1;
    cycle();
    compared++;
    if (op_valid !== 1'b0 || req_ready !== 1'b1) begin
      mismatched++; $display("FAIL mid_release: got v=%b rdy=%b want 0/1", op_valid, req_ready);
    end
    op_ready = 1'b0;
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst             = ($urandom_range(0, 39) != 0);
      w               = ($urandom_range(0, 2) == 0);
      select_register = 4'($urandom);
      s               = 16'($urandom);
      req_valid       = ($urandom_range(0, 2) != 0);
      ra              = 4'($urandom);
      rb              = ($urandom_range(0, 5) == 0) ? ra : 4'($urandom);
      op_ready        = ($urandom_range(0, 2) != 0);
      cycle();
      compared++;
      if (op_valid !== (q.size() > 0) || req_ready !== (rst && q.size() < 2)) begin
        mismatched++;
        $display("FAIL rand_flags_%0d: got v=%b rdy=%b want v=%b rdy=%b",
                 n, op_valid, req_ready, q.size() > 0, rst && q.size() < 2);
      end else if (q.size() > 0) begin
        compared++;
        if (op_a !== q[0].a || op_b !== q[0].b || op_ra !== q[0].ra || op_rb !== q[0].rb) begin
          mismatched++;
          $display("FAIL rand_head_%0d: got a=%h b=%h ra=%0d rb=%0d want a=%h b=%h ra=%0d rb=%0d",
                   n, op_a, op_b, op_ra, op_rb, q[0].a, q[0].b, q[0].ra, q[0].rb);
        end
      end
    end
    rst = 1'b1;
    idle_inputs();
    $display("test_random done");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    test_reset();
    test_basic_read();
    test_bypass();
    test_back_pressure();
    test_streaming();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
